debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
Input conditioner for raw asynchronous pins such as external clock references, strobes and buttons. Synchronizes the pin into the clk domain, then filters bounce/glitches with a programmable stable-count debouncer. Its sense_o drives the sense input of the downstream edge-detect (monostable) stage, so that stage only ever sees clean, synchronous, glitch-free levels. The debounce logic advances only on clk_en strobes, matching the clock-domain enable scheme used throughout the design.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
CNT_WIDTH, 8, width of the stable counter and of stable_cycles_i.
RESET_LEVEL, 1'b0, value loaded into every synchronizer flop and into sense_o on reset.

Ports:
clk  input  1  system clock; the only clock.
async_rst  input  1  asynchronous reset, active-high; de-assertion is synchronized to clk externally.
clk_en  input  1  clock-domain enable strobe; gates the debounce logic only.
debounce_en_i  input  1  1 = filtering active; 0 = bypass (sense_o follows sync_o).
stable_cycles_i  input  CNT_WIDTH  required number of consecutive enabled samples at a new level before sense_o changes.
async_i  input  1  raw pin, asynchronous to clk.
sync_o  output  1  synchronized raw level (last synchronizer stage).
sense_o  output  1  debounced level; feeds the downstream edge detector.
settling_o  output  1  high while the FSM is in SETTLING.
bounce_o  output  1  one-clk pulse when a pending level change is aborted.

Behaviour:
- Reset (async_rst=1, asserts immediately, no clk edge needed):
  - all synchronizer flops = RESET_LEVEL; sense_o = RESET_LEVEL;
  - state = STABLE; count = 0; settling_o = 0; bounce_o = 0.
- Synchronizer:
  - shifts on every clk edge, not gated by clk_en;
  - sync_o reflects async_i after SYNC_STAGES edges.
- FSM states: STABLE, SETTLING. It evaluates only on clk edges with clk_en=1; all state holds on edges without clk_en.
- debounce_en_i=0:
  - each enabled edge sets sense_o <= sync_o;
  - state forced to STABLE, count = 0, no bounce_o.
- Bypass threshold: stable_cycles_i of 0 or 1 behaves identically. In STABLE with sync_o != sense_o, sense_o <= sync_o on that enabled edge and the FSM stays in STABLE.
- STABLE, sync_o != sense_o, stable_cycles_i >= 2: go to SETTLING, count <= 1.
- SETTLING, sync_o == sense_o: abort. Go to STABLE, count <= 0, bounce_o set.
- SETTLING, sync_o != sense_o:
  - if count+1 >= stable_cycles_i: commit. sense_o <= sync_o, go to STABLE, count <= 0.
  - else count <= count+1.
- stable_cycles_i is sampled live with no latching. If it is lowered below count mid-settle, the next differing sample commits (>= compare).
- count never exceeds stable_cycles_i-1, so there is no overflow or wrap. Compare count+1 at CNT_WIDTH+1 bits.
- Latency, clk_en held high: sense_o changes stable_cycles_i enabled edges after sync_o changes. The first enabled edge seeing the new level counts as sample 1.
- bounce_o: registered. Set on the aborting enabled edge; cleared on the next clk edge regardless of clk_en.
- settling_o = (state == SETTLING), registered.
- Reset mid-SETTLING discards the pending change; sense_o returns to RESET_LEVEL.

Test Plan:
1. Reset: pulse async_rst between clk edges with RESET_LEVEL=0, and again with RESET_LEVEL=1 -> sense_o, sync_o, settling_o and bounce_o reach reset values before the next clk edge.
2. Clean rise: SYNC_STAGES=2, stable_cycles_i=4, clk_en=1, async_i 0->1 before edge 1 -> sync_o=1 after edge 2; settling_o=1 after edge 3; sense_o=1 after edge 6; settling_o=0 after edge 6.
3. Glitch: stable_cycles_i=4, async_i high for 2 clk cycles only -> sense_o stays 0; bounce_o high for exactly 1 cycle; settling_o returns to 0; no change is ever committed.
4. Strobed enable: clk_en high every 3rd clk, stable_cycles_i=3 -> sense_o changes on the 3rd enabled edge after sync_o changes; count holds on non-enabled edges.
5. Bypass: debounce_en_i=0, and separately stable_cycles_i=0 and stable_cycles_i=1 -> sense_o follows sync_o on the next enabled edge; settling_o and bounce_o stay 0.
6. Mid-settle events:
   - lower stable_cycles_i from 10 to 2 while count=5 -> commit on the next differing enabled edge;
   - assert async_rst while count=3 -> count=0, state=STABLE, sense_o=RESET_LEVEL.

Source files
------------

// File: rtl/debounce_sync.sv
// Pin conditioner: multi-flop synchronizer followed by a clk_en-gated
// stable-count debouncer whose clean level drives a downstream edge detector.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 async_rst,
  input  logic                 clk_en,
  input  logic                 debounce_en_i,
  input  logic [CNT_WIDTH-1:0] stable_cycles_i,
  input  logic                 async_i,
  output logic                 sync_o,
  output logic                 sense_o,
  output logic                 settling_o,
  output logic                 bounce_o
);

  localparam int unsigned CNT_W1 = CNT_WIDTH + 1;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_sense;
  logic                   r_settling;
  logic                   r_bounce;

  logic                   w_sync;
  logic                   w_differs;
  logic                   w_bypass;
  logic [CNT_W1-1:0]      w_cnt_inc;
  logic                   w_commit;

  // Synchronizer runs every clk edge; clk_en only gates the filter.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_sync != r_sense);
  assign w_bypass  = (CNT_W1'(stable_cycles_i) < CNT_W1'(2));
  // One extra bit so count+1 can never wrap before the compare.
  assign w_cnt_inc = CNT_W1'(r_count) + CNT_W1'(1);
  assign w_commit  = (w_cnt_inc >= CNT_W1'(stable_cycles_i));

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state    <= ST_STABLE;
      r_count    <= '0;
      r_sense    <= RESET_LEVEL;
      r_settling <= 1'b0;
      r_bounce   <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      if (clk_en) begin
        if (!debounce_en_i) begin
          r_sense    <= w_sync;
          r_state    <= ST_STABLE;
          r_count    <= '0;
          r_settling <= 1'b0;
        end else begin
          case (r_state)
            ST_STABLE: begin
              if (w_differs) begin
                if (w_bypass) begin
                  r_sense <= w_sync;
                end else begin
                  r_state    <= ST_SETTLING;
                  r_count    <= CNT_WIDTH'(1);
                  r_settling <= 1'b1;
                end
              end
            end
            ST_SETTLING: begin
              if (!w_differs) begin
                r_state    <= ST_STABLE;
                r_count    <= '0;
                r_settling <= 1'b0;
                r_bounce   <= 1'b1;
              end else if (w_commit) begin
                r_sense    <= w_sync;
                r_state    <= ST_STABLE;
                r_count    <= '0;
                r_settling <= 1'b0;
              end else begin
                r_count <= r_count + CNT_WIDTH'(1);
              end
            end
            default: begin
              r_state    <= ST_STABLE;
              r_count    <= '0;
              r_settling <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign sync_o     = w_sync;
  assign sense_o    = r_sense;
  assign settling_o = r_settling;
  assign bounce_o   = r_bounce;

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized and directed bench for debounce_sync; two instances with different
// depth/reset level are compared against a run-length reference model.
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       async_rst;
  logic       clk_en;
  logic       debounce_en;
  logic [7:0] stable_cycles;
  logic       async_in;

  logic sync_a, sense_a, settling_a, bounce_a;
  logic sync_b, sense_b, settling_b, bounce_b;

  int checks   = 0;
  int failures = 0;

  // Reference model: sync value = pin delayed by the stage count; the filter is
  // a run length of consecutive enabled samples that disagree with sense.
  int stg[2];
  bit rl[2];
  int m_run[2];
  bit m_sense[2];
  bit m_bounce[2];
  bit m_hist[2][4];

  debounce_sync #(.SYNC_STAGES(2), .CNT_WIDTH(8), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .debounce_en_i(debounce_en),
    .stable_cycles_i(stable_cycles), .async_i(async_in),
    .sync_o(sync_a), .sense_o(sense_a), .settling_o(settling_a), .bounce_o(bounce_a)
  );

  debounce_sync #(.SYNC_STAGES(3), .CNT_WIDTH(8), .RESET_LEVEL(1'b1)) dut_b (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .debounce_en_i(debounce_en),
    .stable_cycles_i(stable_cycles), .async_i(async_in),
    .sync_o(sync_b), .sense_o(sense_b), .settling_o(settling_b), .bounce_o(bounce_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]    = 0;
      m_sense[i]  = rl[i];
      m_bounce[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_hist[i][k] = rl[i];
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      bit s;
      int thr;
      s   = m_hist[i][stg[i]-1];
      thr = int'(stable_cycles);
      m_bounce[i] = 1'b0;
      if (clk_en) begin
        if (!debounce_en) begin
          m_sense[i] = s;
          m_run[i]   = 0;
        end else if (s == m_sense[i]) begin
          if (m_run[i] > 0) m_bounce[i] = 1'b1;
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= thr) begin
            m_sense[i] = s;
            m_run[i]   = 0;
          end
        end
      end
      for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = async_in;
    end
  endfunction

  task automatic compare_all();
    check("a_sync",     sync_a,     m_hist[0][1]);
    check("a_sense",    sense_a,    m_sense[0]);
    check("a_settling", settling_a, m_run[0] > 0);
    check("a_bounce",   bounce_a,   m_bounce[0]);
    check("b_sync",     sync_b,     m_hist[1][2]);
    check("b_sense",    sense_b,    m_sense[1]);
    check("b_settling", settling_b, m_run[1] > 0);
    check("b_bounce",   bounce_b,   m_bounce[1]);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse();
    async_rst = 1'b1;
    #1;
    check("rst_a_sync",     sync_a,     1'b0);
    check("rst_a_sense",    sense_a,    1'b0);
    check("rst_a_settling", settling_a, 1'b0);
    check("rst_a_bounce",   bounce_a,   1'b0);
    check("rst_b_sync",     sync_b,     1'b1);
    check("rst_b_sense",    sense_b,    1'b1);
    check("rst_b_settling", settling_b, 1'b0);
    check("rst_b_bounce",   bounce_b,   1'b0);
    model_reset();
    #1;
    async_rst = 1'b0;
  endtask

  initial begin
    int n_bounce;
    int n_high;
    stg = '{2, 3};
    rl  = '{1'b0, 1'b1};
    async_rst     = 1'b1;
    clk_en        = 1'b1;
    debounce_en   = 1'b1;
    stable_cycles = 8'd4;
    async_in      = 1'b0;
    @(posedge clk);
    #1;
    rst_pulse();

    // Clean rise with threshold 4.
    repeat (8) tick();
    async_in = 1'b1;
    tick();
    check("t2_sync_e1", sync_a, 1'b0);
    tick();
    check("t2_sync_e2", sync_a, 1'b1);
    tick();
    check("t2_settle_e3", settling_a, 1'b1);
    tick();
    tick();
    check("t2_sense_e5", sense_a, 1'b0);
    tick();
    check("t2_sense_e6", sense_a, 1'b1);
    check("t2_settle_e6", settling_a, 1'b0);

    // Two-cycle glitch must abort with a single bounce pulse.
    async_in = 1'b0;
    repeat (10) tick();
    n_bounce = 0;
    n_high   = 0;
    async_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) async_in = 1'b0;
      tick();
      if (bounce_a) n_bounce++;
      if (sense_a) n_high++;
    end
    check("t3_one_bounce", n_bounce == 1, 1'b1);
    check("t3_no_commit", n_high == 0, 1'b1);
    check("t3_settle_end", settling_a, 1'b0);

    // Strobed enable every third clock.
    stable_cycles = 8'd3;
    async_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      clk_en = (c % 3 == 0);
      tick();
    end
    async_in = 1'b0;
    for (int c = 0; c < 30; c++) begin
      clk_en = (c % 3 == 1);
      tick();
    end
    clk_en = 1'b1;

    // Bypass via debounce_en_i=0, then thresholds 0 and 1.
    for (int mode = 0; mode < 3; mode++) begin
      debounce_en   = (mode != 0);
      stable_cycles = (mode == 2) ? 8'd1 : 8'd0;
      for (int c = 0; c < 20; c++) begin
        async_in = 1'($urandom_range(0, 1));
        tick();
      end
    end
    debounce_en = 1'b1;

    // Threshold lowered from 10 to 2 while five samples into a settle.
    stable_cycles = 8'd10;
    async_in = 1'b0;
    repeat (16) tick();
    async_in = 1'b1;
    repeat (7) tick();
    check("t6_settling_c5", settling_a, 1'b1);
    check("t6_sense_hold", sense_a, 1'b0);
    stable_cycles = 8'd2;
    tick();
    check("t6_commit", sense_a, 1'b1);
    check("t6_settle_done", settling_a, 1'b0);

    // Reset three samples into a settle discards the pending change.
    stable_cycles = 8'd4;
    async_in = 1'b0;
    repeat (5) tick();
    check("t6_pre_rst_settle", settling_a, 1'b1);
    rst_pulse();
    async_in = 1'b1;
    repeat (12) tick();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 5) == 0) async_in = ~async_in;
      clk_en      = ($urandom_range(0, 3) != 0);
      debounce_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 40) == 0) stable_cycles = 8'($urandom_range(0, 6));
      tick();
      if ($urandom_range(0, 199) == 0) rst_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
